// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcode fields, funcA/funcB
// codes and FSM state constants.
package ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD      = 3'b000,
        OP_STORE     = 3'b001,
        OP_ADD       = 3'b010,
        OP_MATCH     = 3'b011,
        OP_LT        = 3'b100,
        OP_DIST      = 3'b101,
        OP_HAS_FUNCA = 3'b110,
        OP_HAS_FUNCB = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        FA_LSL  = 3'b000,
        FA_LSR  = 3'b001,
        FA_INCR = 3'b010,
        FA_AND1 = 3'b011,
        FA_EQZ  = 3'b100,
        FA_ZERO = 3'b101,
        FA_TBD  = 3'b110,
        FA_HALT = 3'b111
    } funca_e;

    localparam logic FB_BNO = 1'b0;
    localparam logic FB_BOF = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps a 6-bit opcode onto the handful of
// attributes the sequencer needs.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_branch,
    output logic       is_halt,
    output logic       updates_flag,
    output logic       writes_reg
);

    op_e    op;
    funca_e fa;

    assign op = op_e'(opcode[5:3]);
    assign fa = funca_e'(opcode[2:0]);

    assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign is_load   = (op == OP_LOAD);
    assign is_branch = (op == OP_HAS_FUNCB);
    assign is_halt   = (op == OP_HAS_FUNCA) && (fa == FA_HALT);

    assign updates_flag = (op == OP_ADD) ||
                          ((op == OP_HAS_FUNCA) &&
                           ((fa == FA_LSL) || (fa == FA_LSR) || (fa == FA_INCR)));

    // TBD runs as a NOP; HALT never reaches write-back but is excluded anyway.
    assign writes_reg = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_MATCH) ||
                        (op == OP_LT) || (op == OP_DIST) ||
                        ((op == OP_HAS_FUNCA) && (fa != FA_TBD) && (fa != FA_HALT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with an overflow
// flag, memory handshake timeout and retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit OVF_STICKY  = 1'b0,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic               alu_ovf,
    input  logic               mem_ready,
    output logic               ir_load,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_we,
    output logic               pc_en,
    output logic               branch_taken,
    output logic               ovf_flag,
    output logic               halted,
    output logic               error,
    output logic [COUNT_W-1:0] retired
);

    localparam int WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int WAIT_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [5:0]         opcode_q;
    logic [5:0]         dec_opcode;
    logic               flag;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [COUNT_W-1:0] retired_q;
    logic               timeout_hit;

    logic is_mem, is_load, is_branch, is_halt, updates_flag, writes_reg;

    // DECODE steers on the live IR; every later state sees only the latched copy.
    assign dec_opcode = (state == S_DECODE) ? opcode : opcode_q;

    ctrl_decode u_decode (
        .opcode       (dec_opcode),
        .is_mem       (is_mem),
        .is_load      (is_load),
        .is_branch    (is_branch),
        .is_halt      (is_halt),
        .updates_flag (updates_flag),
        .writes_reg   (writes_reg)
    );

    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_W'(WAIT_LAST));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALTED: if (start) state_nxt = S_FETCH;
            S_FETCH:          state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_mem)         state_nxt = S_MEM;
                else if (is_branch) state_nxt = S_WB;
                else if (is_halt)   state_nxt = S_HALTED;
                else                state_nxt = S_EXEC;
            end
            S_EXEC:           state_nxt = S_WB;
            S_MEM: begin
                if (mem_ready)        state_nxt = S_WB;
                else if (timeout_hit) state_nxt = S_ERROR;
            end
            S_WB:             state_nxt = S_FETCH;
            S_ERROR:          state_nxt = S_ERROR;
            default:          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opcode_q  <= '0;
            flag      <= 1'b0;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_DECODE)
                opcode_q <= opcode;

            if ((state == S_EXEC) && updates_flag)
                flag <= OVF_STICKY ? (flag | alu_ovf) : alu_ovf;
            else if ((state == S_WB) && is_branch && OVF_STICKY)
                flag <= 1'b0;

            // Cleared whenever the next state is not MEM so each access starts at 0.
            if (state_nxt != S_MEM)
                wait_cnt <= '0;
            else if ((state == S_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;

            if (state == S_WB)
                retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        ir_load      = (state == S_FETCH);
        mem_read     = (state == S_MEM) && is_load;
        mem_write    = (state == S_MEM) && is_mem && !is_load;
        reg_we       = (state == S_WB) && writes_reg;
        pc_en        = (state == S_WB);
        branch_taken = (state == S_WB) && is_branch &&
                       ((opcode_q[2] == FB_BOF) ? flag : !flag);
        ovf_flag     = flag;
        halted       = (state == S_IDLE) || (state == S_HALTED) || (state == S_ERROR);
        error        = (state == S_ERROR);
        retired      = retired_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (plain flag with timeout 4, sticky
// flag with timeout disabled and 4-bit counter) share stimulus against a phase model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n, start, alu_ovf, mem_ready;
    logic [5:0] opcode;

    logic        ir0, rd0, wm0, we0, pc0, bt0, of0, hl0, er0;
    logic        ir1, rd1, wm1, we1, pc1, bt1, of1, hl1, er1;
    logic [15:0] ret0;
    logic [3:0]  ret1;
    logic [8:0]  obs0, obs1;

    int          checks = 0;
    int          failures = 0;
    logic        m0, m1;
    logic [15:0] cnt;
    logic        at_fetch;

    assign obs0 = {ir0, rd0, wm0, we0, pc0, bt0, of0, hl0, er0};
    assign obs1 = {ir1, rd1, wm1, we1, pc1, bt1, of1, hl1, er1};

    multicycle_control #(.MEM_TIMEOUT(4), .OVF_STICKY(1'b0), .COUNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_ovf(alu_ovf),
        .mem_ready(mem_ready), .ir_load(ir0), .mem_read(rd0), .mem_write(wm0),
        .reg_we(we0), .pc_en(pc0), .branch_taken(bt0), .ovf_flag(of0),
        .halted(hl0), .error(er0), .retired(ret0)
    );

    multicycle_control #(.MEM_TIMEOUT(0), .OVF_STICKY(1'b1), .COUNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_ovf(alu_ovf),
        .mem_ready(mem_ready), .ir_load(ir1), .mem_read(rd1), .mem_write(wm1),
        .reg_we(we1), .pc_en(pc1), .branch_taken(bt1), .ovf_flag(of1),
        .halted(hl1), .error(er1), .retired(ret1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m0 = 1'b0;
        m1 = 1'b0;
        cnt = '0;
        at_fetch = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        at_fetch = 1'b1;
    endtask

    // Phases: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALTED. Expects to be in FETCH.
    task automatic exec_instr(input string tag, input logic [5:0] op, input logic ovf, input int n);
        int         ph[$];
        int         mi;
        logic       br, hlt, ld, upd, wr, t0, t1;
        logic [8:0] e0, e1;
        br  = (op[5:3] == 3'b111);
        hlt = (op == 6'b110111);
        ld  = (op[5:3] == 3'b000);
        upd = (op[5:3] == 3'b010) || ((op[5:3] == 3'b110) && (op[2:0] <= 3'd2));
        wr  = !br && (op[5:3] != 3'b001) && !((op[5:3] == 3'b110) && (op[2:1] == 2'b11));
        ph.push_back(0);
        ph.push_back(1);
        if (hlt) begin
            ph.push_back(5);
        end else begin
            if (op[5:4] == 2'b00)
                for (int k = 0; k < n; k++) ph.push_back(3);
            else if (!br)
                ph.push_back(2);
            ph.push_back(4);
        end
        mi = 0;
        foreach (ph[i]) begin
            t0 = br && (op[2] ? m0 : !m0);
            t1 = br && (op[2] ? m1 : !m1);
            e0 = {ph[i] == 0, ph[i] == 3 && ld, ph[i] == 3 && !ld, ph[i] == 4 && wr,
                  ph[i] == 4, ph[i] == 4 && t0, m0, ph[i] == 5, 1'b0};
            e1 = {ph[i] == 0, ph[i] == 3 && ld, ph[i] == 3 && !ld, ph[i] == 4 && wr,
                  ph[i] == 4, ph[i] == 4 && t1, m1, ph[i] == 5, 1'b0};
            checks++;
            if ({obs0, ret0} !== {e0, cnt}) begin
                failures++;
                $display("FAIL %s dut0 op=%b phase=%0d: got %b ret=%0d, want %b ret=%0d",
                         tag, op, ph[i], obs0, ret0, e0, cnt);
            end
            checks++;
            if ({obs1, ret1} !== {e1, cnt[3:0]}) begin
                failures++;
                $display("FAIL %s dut1 op=%b phase=%0d: got %b ret=%0d, want %b ret=%0d",
                         tag, op, ph[i], obs1, ret1, e1, cnt[3:0]);
            end
            case (ph[i])
                0: opcode = op;
                2: begin
                    alu_ovf = ovf;
                    if (upd) begin
                        m0 = ovf;
                        m1 = m1 | ovf;
                    end
                end
                3: begin
                    mem_ready = (mi == n - 1);
                    mi++;
                end
                4: begin
                    cnt = cnt + 16'd1;
                    if (br) m1 = 1'b0;
                end
                default: ;
            endcase
            if (ph[i] >= 2) opcode = 6'($urandom);
            if (ph[i] != 2) alu_ovf = 1'($urandom);
            if (ph[i] != 3) mem_ready = 1'($urandom);
            start = (ph[i] == 5) ? 1'b0 : 1'($urandom);
            if (ph[i] != 5) step();
        end
        at_fetch = !hlt;
    endtask

    task automatic ensure_fetch();
        if (!at_fetch) start_run();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        opcode = 6'b010000;
        alu_ovf = 1'b1;
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({obs0, ret0, obs1, ret1} !== {9'b000000010, 16'd0, 9'b000000010, 4'd0}) begin
            failures++;
            $display("FAIL reset_async: got %b/%0d %b/%0d, want idle/0", obs0, ret0, obs1, ret1);
        end
        start = 1'b1;
        step();
        step();
        checks++;
        if ({obs0, obs1} !== {9'b000000010, 9'b000000010}) begin
            failures++;
            $display("FAIL reset_hold: got %b %b, want idle", obs0, obs1);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if ({obs0, obs1} !== {9'b000000010, 9'b000000010}) begin
            failures++;
            $display("FAIL idle_no_start: got %b %b, want idle", obs0, obs1);
        end
    endtask

    task automatic test_add_ovf();
        start_run();
        exec_instr("add_ovf", 6'b010000, 1'b1, 1);
    endtask

    task automatic test_branch();
        ensure_fetch();
        exec_instr("br_add1", 6'b010000, 1'b1, 1);
        exec_instr("br_add0", 6'b010000, 1'b0, 1);
        exec_instr("br_bof", 6'b111100, 1'b0, 1);
        exec_instr("br_bno", 6'b111000, 1'b0, 1);
        exec_instr("br_lsl1", 6'b110000, 1'b1, 1);
        exec_instr("br_bof2", 6'b111100, 1'b0, 1);
        exec_instr("br_and1", 6'b110011, 1'b1, 1);
        exec_instr("br_bno2", 6'b111000, 1'b0, 1);
    endtask

    task automatic test_mem();
        ensure_fetch();
        exec_instr("load_n3", 6'b000000, 1'b0, 3);
        exec_instr("store_n1", 6'b001000, 1'b0, 1);
        exec_instr("load_n4", 6'b000101, 1'b0, 4);
        exec_instr("tbd_nop", 6'b110110, 1'b1, 1);
    endtask

    task automatic test_halt();
        ensure_fetch();
        exec_instr("halt", 6'b110111, 1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({obs0, ret0} !== {7'b0, m0, 1'b1, 1'b0, cnt}) begin
                failures++;
                $display("FAIL halt_hold: got %b ret=%0d, want halted ret=%0d", obs0, ret0, cnt);
            end
        end
        start_run();
        exec_instr("resume", 6'b011000, 1'b0, 1);
    endtask

    task automatic test_timeout();
        ensure_fetch();
        opcode = 6'b000000;
        mem_ready = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rd0, er0, rd1, er1} !== 4'b1010) begin
                failures++;
                $display("FAIL timeout_mem%0d: got rd/err %b, want 1010", k, {rd0, er0, rd1, er1});
            end
            step();
        end
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({obs0, ret0} !== {6'b0, m0, 1'b1, 1'b1, cnt}) begin
                failures++;
                $display("FAIL timeout_error%0d: got %b ret=%0d, want error ret=%0d", k, obs0, ret0, cnt);
            end
            checks++;
            if ({rd1, er1, hl1} !== 3'b100) begin
                failures++;
                $display("FAIL no_timeout_dut1: got %b, want 100", {rd1, er1, hl1});
            end
            step();
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({obs0, ret0, obs1, ret1} !== {9'b000000010, 16'd0, 9'b000000010, 4'd0}) begin
            failures++;
            $display("FAIL error_reset: got %b/%0d %b/%0d, want idle/0", obs0, ret0, obs1, ret1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int k = 0; k < 60; k++) begin
            ensure_fetch();
            op = 6'($urandom);
            exec_instr("random", op, 1'($urandom), int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_reset_mid_mem();
        ensure_fetch();
        opcode = 6'b001010;
        mem_ready = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({wm0, wm1} !== 2'b11) begin
            failures++;
            $display("FAIL mid_mem_write: got %b, want 11", {wm0, wm1});
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({obs0, ret0, obs1, ret1} !== {9'b000000010, 16'd0, 9'b000000010, 4'd0}) begin
            failures++;
            $display("FAIL mid_mem_reset: got %b/%0d %b/%0d, want idle/0", obs0, ret0, obs1, ret1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({obs0, obs1} !== {9'b000000010, 9'b000000010}) begin
            failures++;
            $display("FAIL post_reset_idle: got %b %b, want idle", obs0, obs1);
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_branch();
        test_mem();
        test_halt();
        test_timeout();
        test_random();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
